// File: rtl/hex_scroll_ctrl.sv
// Scrolling eight-digit window onto a 16-entry message buffer for the active-low
// seven-segment bank, with run/pause/single-step/clear control and a wrap pulse.
module hex_scroll_ctrl #(
  parameter int CNT_W       = 24,
  parameter int STEP_CYCLES = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLEAR,
  input  logic       STEP,
  input  logic       DIR,
  input  logic       WR_EN,
  input  logic [3:0] WR_ADDR,
  input  logic [3:0] WR_DATA,
  output logic [7:0] HEX7,
  output logic [7:0] HEX6,
  output logic [7:0] HEX5,
  output logic [7:0] HEX4,
  output logic [7:0] HEX3,
  output logic [7:0] HEX2,
  output logic [7:0] HEX1,
  output logic [7:0] HEX0,
  output logic [1:0] STATE,
  output logic [3:0] OFFSET,
  output logic       WRAP
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       offset_q, offset_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             advance;
  logic [3:0]       msg_q [16];
  logic [7:0]       hex_q [8];

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(STEP_CYCLES - 1);

  function automatic logic [7:0] seg(input logic [3:0] code);
    logic [7:0] s;
    case (code)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Control priority is CLEAR > STOP > START > STEP in every state.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    presc_d  = presc_q;
    advance  = 1'b0;
    wrap_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!CLEAR && !STOP && START) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (CLEAR) begin
          state_d  = S_IDLE;
          offset_d = 4'd0;
          presc_d  = '0;
        end else if (STOP) begin
          state_d = S_PAUSE;
        end else if (presc_q == LAST_TICK) begin
          presc_d = '0;
          advance = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (CLEAR) begin
          state_d  = S_IDLE;
          offset_d = 4'd0;
          presc_d  = '0;
        end else if (STOP) begin
          state_d = S_PAUSE;
        end else if (START) begin
          state_d = S_RUN;
        end else if (STEP) begin
          advance = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        offset_d = 4'd0;
        presc_d  = '0;
      end
    endcase
    if (advance) begin
      offset_d = DIR ? offset_q - 4'd1 : offset_q + 4'd1;
      wrap_d   = DIR ? (offset_q == 4'd0) : (offset_q == 4'd15);
    end
  end

  // Display registers read the already-committed offset/buffer/state,
  // which gives the one-cycle latency from any change to the digits.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      offset_q <= 4'd0;
      presc_q  <= '0;
      wrap_q   <= 1'b0;
      for (int i = 0; i < 16; i++) msg_q[i] <= 4'hF;
      for (int k = 0; k < 8; k++) hex_q[k] <= 8'hFF;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      presc_q  <= presc_d;
      wrap_q   <= wrap_d;
      if (WR_EN) msg_q[WR_ADDR] <= WR_DATA;
      for (int k = 0; k < 8; k++)
        hex_q[k] <= (state_q == S_IDLE) ? 8'hFF : seg(msg_q[offset_q + 4'(7 - k)]);
    end
  end

  assign HEX7   = hex_q[7];
  assign HEX6   = hex_q[6];
  assign HEX5   = hex_q[5];
  assign HEX4   = hex_q[4];
  assign HEX3   = hex_q[3];
  assign HEX2   = hex_q[2];
  assign HEX1   = hex_q[1];
  assign HEX0   = hex_q[0];
  assign STATE  = state_q;
  assign OFFSET = offset_q;
  assign WRAP   = wrap_q;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with a fast prescaler: expected display
// windows go through a queue, scalar outputs are checked against constants.
module tb_hex_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, clear, step, dir, wr_en;
  logic [3:0] wr_addr, wr_data;
  logic [7:0] hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
  logic [1:0] state;
  logic [3:0] offset;
  logic       wrap;
  logic [63:0] hex_all;

  int n_vec = 0;
  int n_err = 0;
  int wrap_cnt;

  logic [63:0] exp_q [$];
  logic [3:0]  mbuf [16];
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'hFF};
  localparam logic [63:0] ALL_BLANK = 64'hFFFF_FFFF_FFFF_FFFF;

  hex_scroll_ctrl #(.CNT_W(24), .STEP_CYCLES(4)) dut (
    .CLOCK_50(clk), .RST_N(rst_n), .START(start), .STOP(stop), .CLEAR(clear),
    .STEP(step), .DIR(dir), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .HEX7(hex7), .HEX6(hex6), .HEX5(hex5), .HEX4(hex4),
    .HEX3(hex3), .HEX2(hex2), .HEX1(hex1), .HEX0(hex0),
    .STATE(state), .OFFSET(offset), .WRAP(wrap)
  );

  assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard
  function automatic logic [63:0] window(input logic [3:0] off);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[63 - 8*k -: 8] = seg_tab[mbuf[off + 4'(k)]];
    return r;
  endfunction

  task automatic expect_win(input logic [3:0] off);
    exp_q.push_back(window(off));
  endtask

  task automatic check_win(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    chk(tag, hex_all, e);
  endtask

  // drivers
  task automatic write_buf(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    mbuf[a] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; step = 1'b0;
    dir = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
    for (int i = 0; i < 16; i++) mbuf[i] = 4'hF;

    // reset / idle
    tick(); tick();
    chk("reset_hex", hex_all, ALL_BLANK);
    chk("reset_state", state, 2'b00);
    chk("reset_offset", offset, 4'd0);
    chk("reset_wrap", wrap, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) write_buf(4'(i), 4'(i));
    tick(); tick();
    chk("idle_blank", hex_all, ALL_BLANK);
    chk("idle_state", state, 2'b00);

    // run left
    for (int i = 8; i < 16; i++) write_buf(4'(i), 4'(i));
    pulse_start();
    chk("run_state", state, 2'b01);
    chk("run_offset0", offset, 4'd0);
    tick(); tick(); tick();
    chk("run_no_tick_yet", offset, 4'd0);
    tick();
    chk("run_first_tick", offset, 4'd1);
    expect_win(4'd0);
    check_win("win_offset0");
    expect_win(4'd1);
    tick();
    check_win("win_offset1");
    wrap_cnt = 0;
    for (int i = 0; i < 59; i++) begin
      tick();
      if (wrap === 1'b1) wrap_cnt++;
    end
    chk("left_wrap_now", wrap, 1'b1);
    chk("left_wrap_offset", offset, 4'd0);
    chk("left_wrap_count", 64'(wrap_cnt), 64'd1);
    tick();
    chk("left_wrap_drop", wrap, 1'b0);

    // right wrap
    dir = 1'b1;
    tick(); tick();
    chk("right_pre", offset, 4'd0);
    tick();
    chk("right_wrap_offset", offset, 4'd15);
    chk("right_wrap_pulse", wrap, 1'b1);
    expect_win(4'd15);
    tick();
    check_win("win_offset15");
    chk("right_hex7_blank", hex7, 8'hFF);
    chk("right_hex6_zero", hex6, 8'hC0);
    chk("right_wrap_drop", wrap, 1'b0);

    // pause / step
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("pause_state", state, 2'b10);
    for (int i = 0; i < 20; i++) tick();
    chk("pause_frozen", offset, 4'd15);
    dir = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_offset", offset, 4'd0);
    chk("step_wrap", wrap, 1'b1);
    pulse_start();
    chk("resume_state", state, 2'b01);
    tick();
    chk("resume_no_tick", offset, 4'd0);
    tick();
    chk("resume_tick", offset, 4'd1);

    // priority / clear
    start = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("start_stop_pause", state, 2'b10);
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    chk("clear_state", state, 2'b00);
    chk("clear_offset", offset, 4'd0);
    tick();
    chk("clear_blank", hex_all, ALL_BLANK);
    pulse_start();
    expect_win(4'd0);
    tick();
    check_win("buffer_kept");

    // mid-run write and reset
    write_buf(4'd0, 4'hA);
    expect_win(4'd0);
    tick();
    check_win("write_visible");
    chk("write_hex7", hex7, 8'h88);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_state", state, 2'b00);
    chk("midrst_offset", offset, 4'd0);
    chk("midrst_wrap", wrap, 1'b0);
    chk("midrst_hex", hex_all, ALL_BLANK);
    for (int i = 0; i < 16; i++) mbuf[i] = 4'hF;
    pulse_start();
    expect_win(4'd0);
    tick();
    check_win("buffer_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hex_scroll_ctrl.md
Name: hex_scroll_ctrl

Overview:
- Sequencing controller for the 8-digit active-low seven-segment bank (HEX7..HEX0).
- Holds a 16-entry message buffer of 4-bit character codes and shows an 8-digit window onto it.
- Scrolls the window at a programmable rate and provides run/pause/single-step/clear control.
- Replaces static per-switch decode blocks as the display driver for message and status screens.

Parameters:
STEP_CYCLES, 12500000, clock cycles per scroll step (0.25 s at 50 MHz); legal range 2..2^CNT_W-1.
CNT_W, 24, prescaler width.

Ports:
CLOCK_50  input  1  sole clock; all state changes on its rising edge.
RST_N  input  1  reset, synchronous, active-low.
START  input  1  level-sampled; enter/resume scrolling.
STOP  input  1  level-sampled; pause scrolling.
CLEAR  input  1  level-sampled; return to IDLE, offset 0.
STEP  input  1  single-cycle pulse; advance one position while paused.
DIR  input  1  0 = scroll left (offset+1), 1 = scroll right (offset-1).
WR_EN  input  1  buffer write strobe.
WR_ADDR  input  4  buffer entry to write.
WR_DATA  input  4  character code to store.
HEX7..HEX0  output  8 each  registered segment patterns, active-low, bit7 = DP (always 1).
STATE  output  2  00 IDLE, 01 RUN, 10 PAUSE.
OFFSET  output  4  current window start index.
WRAP  output  1  one-cycle pulse when the offset wraps.

Behaviour:
- Reset (RST_N=0 at edge): STATE=IDLE, OFFSET=0, prescaler=0, all 16 buffer entries=4'hF, HEX7..HEX0=8'hFF, WRAP=0.
  - Reset asserted mid-scroll aborts immediately; takes priority over every other input.
- Character decode:
  - Codes 0..9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - Codes A..E (letters A b C d E): 88 83 C6 A1 86.
  - Code F: FF (blank).
- Window: HEXk shows buf[(OFFSET + (7-k)) mod 16]. HEX7 is the leftmost digit and shows buf[OFFSET].
- Output registers: HEX is registered from current OFFSET, buffer and STATE.
  - Any change committed at edge n appears on HEX after edge n+1 (one-cycle output latency).
  - In IDLE all HEX = FF regardless of buffer contents.
- Control priority per cycle: CLEAR > STOP > START > STEP.
- FSM:
  - IDLE: START -> RUN with prescaler=0. STOP and STEP are ignored.
  - RUN:
    - STOP -> PAUSE; prescaler holds its value.
    - CLEAR -> IDLE; OFFSET=0, prescaler=0.
    - Otherwise the prescaler increments each cycle.
    - At prescaler = STEP_CYCLES-1 the prescaler returns to 0 and OFFSET advances by one per DIR (DIR sampled that cycle).
  - PAUSE:
    - START -> RUN; prescaler resumes from its held value.
    - STEP (with no higher-priority input) advances OFFSET by one per DIR; the prescaler is untouched.
    - CLEAR -> IDLE.
- Wrap-around: OFFSET is mod 16. WRAP=1 for exactly the cycle after an advance 15->0 (left) or 0->15 (right). Otherwise WRAP=0.
- Buffer writes:
  - Accepted in every state, one per cycle.
  - A write at edge n is visible on HEX after edge n+1.
  - A write and an advance in the same cycle both take effect; the display shows the new offset with the new data.
  - CLEAR does not erase the buffer.
- START held continuously in RUN has no effect. STOP and START together: STOP wins.

Test Plan:
- Reset/idle (STEP_CYCLES=4): hold RST_N=0 2 cycles -> all HEX=FF, STATE=00, OFFSET=0, WRAP=0. Write buf[0..7]=0..7, no START -> HEX stays all FF.
- Run left: buf[i]=i for i=0..15, pulse START -> STATE=01. After 4 cycles OFFSET=1, and one cycle later HEX7..HEX0 = F9 A4 B0 99 92 82 F8 80. After 16 steps OFFSET=0 and WRAP pulses exactly once.
- Right wrap: DIR=1 from OFFSET=0 -> at the first tick OFFSET=15, WRAP=1 for one cycle, HEX7=8E-free check: HEX7 shows code F = FF, HEX6 shows code 0 = C0.
- Pause/step: STOP at prescaler=2 -> STATE=10, OFFSET frozen for 20 cycles. One STEP pulse -> OFFSET+1. START -> next tick after 2 more cycles (prescaler resumed from 2).
- Priority/clear: assert START+STOP in RUN -> PAUSE. Assert CLEAR+START -> IDLE, OFFSET=0, HEX all FF, buffer preserved (a later START shows the old data).
- Mid-run reset and write: write buf[OFFSET]=A during RUN -> HEX7=88 two cycles after the write. Assert RST_N=0 mid-run -> all outputs at reset values on the next edge, buffer all F.
